axis_gen_traffic_scheduler: RTL
===============================

// Module: axis_gen_traffic_scheduler
// PURPOSE
//  Sequences the AXIS test-pattern generator for RoCE throughput runs. Issues start/stop/length to
//  the generator for a programmed number of frames with a programmed inter-frame gap. Taps the
//  generator's output handshake to count frames/bytes and detect stalls. Sits between the CSR
//  block and the generator, ahead of the RoCE TX path.
// PARAMETERS
//  DATA_WIDTH      64      generator/monitor tdata width; tkeep width = DATA_WIDTH/8
//  START_HOLD      2       cycles gen_start is held high per frame (>=2; generator is edge-based)
//  TIMEOUT_WIDTH   24      width of per-frame watchdog counter
// PORTS
//  clk             in   1          clock
//  rst             in   1          synchronous, active-high reset
//  cfg_go          in   1          1-cycle pulse: latch cfg_*, begin run (ignored when busy)
//  cfg_abort       in   1          1-cycle pulse: stop run after current frame terminates
//  cfg_num_frames  in   32         frames per run; 0 = run completes immediately
//  cfg_frame_len   in   32         frame length in bytes; 0 = illegal
//  cfg_gap_cycles  in   16         idle cycles between tlast handshake and next start
//  cfg_timeout     in   TIMEOUT_WIDTH  max cycles without a monitor handshake while RUN
//  gen_start       out  1          generator start level
//  gen_stop        out  1          generator stop, 1-cycle pulse
//  gen_length      out  32         generator length, stable from ARM entry to frame end
//  mon_tvalid      in   1          tap of generator m_axis_tvalid
//  mon_tready      in   1          tap of downstream tready
//  mon_tlast       in   1          tap of generator m_axis_tlast
//  mon_tkeep       in   DATA_WIDTH/8   tap of generator m_axis_tkeep
//  mon_tuser       in   1          tap of generator m_axis_tuser (frame truncated by stop)
//  busy            out  1          high in any state except IDLE
//  done            out  1          1-cycle pulse on return to IDLE after a run
//  frames_sent     out  32         completed frames this run (tlast handshakes)
//  frames_trunc    out  32         frames ending with mon_tuser=1 on tlast beat
//  bytes_sent      out  64         sum of popcount(mon_tkeep) over handshakes this run
//  err_cfg         out  1          sticky: cfg_go with cfg_frame_len==0; run not started
//  err_timeout     out  1          sticky: watchdog expired; run terminated
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, counters 0; rst mid-run abandons run, no done pulse.
//  Handshake beat hs = mon_tvalid & mon_tready; last beat = hs & mon_tlast.
//  FSM: IDLE -> ARM -> RUN -> GAP -> ARM ... -> IDLE; ABORT reachable from ARM/RUN/GAP.
//  IDLE: on cfg_go latch cfg_*, clear counters and err_*. len==0 -> set err_cfg, stay IDLE,
//    done pulses next cycle. num_frames==0 -> done next cycle, stay IDLE. Else -> ARM.
//  ARM: gen_length=latched len; gen_start=1 for exactly START_HOLD cycles, then gen_start=0,
//    -> RUN. gen_length valid the cycle gen_start first rises.
//  RUN: each hs adds popcount(mon_tkeep) to bytes_sent, reloads watchdog. On last beat:
//    frames_sent++, frames_trunc++ if mon_tuser; if frames_sent+1==num_frames -> IDLE with done;
//    else gap==0 -> ARM next cycle, else -> GAP.
//  GAP: count cfg_gap_cycles cycles exactly (tlast beat to next gen_start rise = gap+1 cycles).
//  Abort (cfg_abort while busy): in RUN assert gen_stop 1 cycle, wait last beat (counted),
//    then IDLE+done. In ARM finish hold, then stop as RUN. In GAP -> IDLE+done at once.
//    Abort with cfg_go same cycle in IDLE: cfg_go wins, abort ignored. Repeated abort: ignored.
//  Watchdog: in RUN, counts cycles since last hs (or since RUN entry); reaching cfg_timeout
//    sets err_timeout, pulses gen_stop, -> IDLE+done. cfg_timeout==0 disables watchdog.
//  Counters saturate: frames_* at 2^32-1, bytes_sent at 2^64-1. cfg_go while busy ignored.
//  Latency: cfg_go to gen_start rise = 1 cycle; last beat to done = 1 cycle.
// TESTING
//  go, num=3, len=100, gap=4, DW=64, tready=1 -> frames_sent=3, bytes_sent=300, 1 done, 4-cycle gaps.
//  go, len=0 -> err_cfg=1, no gen_start, done pulse; num=0 -> done, counters 0.
//  num=10, abort mid-frame 2 -> gen_stop pulse, tuser on tlast, frames_sent=2, frames_trunc=1.
//  tready held 0 for 50 cycles, timeout=20 -> err_timeout=1, gen_stop pulse, done.
//  len=13, DW=64 -> last beat tkeep=0x1F, bytes_sent=13/frame; random tready -> same totals.
//  rst asserted during RUN -> all outputs 0 next cycle, no done; fresh go runs normally.

Source files
------------

// File: rtl/axis_gen_traffic_scheduler.sv
// axis_gen_traffic_scheduler: sequences the AXIS pattern generator and gathers per-run frame/byte stats
//   cfg_*            run configuration, latched on cfg_go; cfg_abort ends a run early
//   gen_start/stop   generator start level (held START_HOLD cycles) and 1-cycle stop pulse
//   gen_length       frame length presented to the generator
//   mon_*            taps of the generator output handshake
//   busy/done        run in progress / 1-cycle end-of-run pulse
//   frames_*/bytes   saturating per-run counters; err_* sticky per-run error flags
module axis_gen_traffic_scheduler #(
  parameter int DATA_WIDTH    = 64,
  parameter int START_HOLD    = 2,
  parameter int TIMEOUT_WIDTH = 24
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_go,
  input  logic                      cfg_abort,
  input  logic [31:0]               cfg_num_frames,
  input  logic [31:0]               cfg_frame_len,
  input  logic [15:0]               cfg_gap_cycles,
  input  logic [TIMEOUT_WIDTH-1:0]  cfg_timeout,
  output logic                      gen_start,
  output logic                      gen_stop,
  output logic [31:0]               gen_length,
  input  logic                      mon_tvalid,
  input  logic                      mon_tready,
  input  logic                      mon_tlast,
  input  logic [DATA_WIDTH/8-1:0]   mon_tkeep,
  input  logic                      mon_tuser,
  output logic                      busy,
  output logic                      done,
  output logic [31:0]               frames_sent,
  output logic [31:0]               frames_trunc,
  output logic [63:0]               bytes_sent,
  output logic                      err_cfg,
  output logic                      err_timeout
);
  localparam int KW = DATA_WIDTH / 8;
  localparam int CW = $clog2(KW + 1);
  localparam int HW = $clog2(START_HOLD + 1);

  // S_STOP: stop has been issued, waiting for the generator's final (truncated) beat
  typedef enum logic [2:0] {S_IDLE, S_ARM, S_RUN, S_GAP, S_STOP} state_t;

  state_t                   state_q, state_d;
  logic [31:0]              num_q, num_d, len_q, len_d;
  logic [15:0]              gap_q, gap_d, gcnt_q, gcnt_d;
  logic [TIMEOUT_WIDTH-1:0] tmo_q, tmo_d, wd_q, wd_d;
  logic [HW-1:0]            hold_q, hold_d;
  logic                     abort_q, abort_d, stop_q, stop_d, done_q, done_d;
  logic                     ecfg_q, ecfg_d, etmo_q, etmo_d;
  logic [31:0]              frames_q, frames_d, trunc_q, trunc_d;
  logic [63:0]              bytes_q, bytes_d;

  logic          hs, last, tracking, wd_exp;
  logic [CW-1:0] keep_cnt;
  logic [64:0]   bytes_sum;
  logic [31:0]   frames_inc, trunc_inc;

  always_comb begin
    keep_cnt = '0;
    for (int i = 0; i < KW; i++) keep_cnt = keep_cnt + CW'(mon_tkeep[i]);
  end

  assign hs         = mon_tvalid & mon_tready;
  assign last       = hs & mon_tlast;
  // the stop-wait state is still part of the frame, so it is counted and watched like RUN
  assign tracking   = (state_q == S_RUN) || (state_q == S_STOP);
  assign wd_exp     = tracking && !hs && (tmo_q != '0) && (wd_q + TIMEOUT_WIDTH'(1) == tmo_q);
  assign bytes_sum  = {1'b0, bytes_q} + 65'(keep_cnt);
  assign frames_inc = &frames_q ? frames_q : frames_q + 32'd1;
  assign trunc_inc  = &trunc_q ? trunc_q : trunc_q + 32'd1;

  always_comb begin
    state_d  = state_q;
    num_d    = num_q;
    len_d    = len_q;
    gap_d    = gap_q;
    tmo_d    = tmo_q;
    gcnt_d   = gcnt_q;
    hold_d   = hold_q;
    abort_d  = abort_q;
    stop_d   = 1'b0;
    done_d   = 1'b0;
    ecfg_d   = ecfg_q;
    etmo_d   = etmo_q;
    frames_d = frames_q;
    trunc_d  = trunc_q;
    bytes_d  = bytes_q;
    wd_d     = tracking ? (hs ? '0 : wd_q + TIMEOUT_WIDTH'(1)) : wd_q;
    if (tracking && hs) bytes_d = bytes_sum[64] ? '1 : bytes_sum[63:0];
    if (tracking && last) begin
      frames_d = frames_inc;
      trunc_d  = mon_tuser ? trunc_inc : trunc_q;
    end
    case (state_q)
      S_IDLE: if (cfg_go) begin
        num_d    = cfg_num_frames;
        len_d    = cfg_frame_len;
        gap_d    = cfg_gap_cycles;
        tmo_d    = cfg_timeout;
        frames_d = '0;
        trunc_d  = '0;
        bytes_d  = '0;
        etmo_d   = 1'b0;
        ecfg_d   = cfg_frame_len == '0;
        done_d   = (cfg_frame_len == '0) || (cfg_num_frames == '0);
        hold_d   = '0;
        abort_d  = 1'b0;
        state_d  = done_d ? S_IDLE : S_ARM;
      end
      S_ARM: begin
        abort_d = abort_q | cfg_abort;
        hold_d  = hold_q + HW'(1);
        if (hold_q == HW'(START_HOLD - 1)) begin
          wd_d    = '0;
          stop_d  = abort_d;
          state_d = abort_d ? S_STOP : S_RUN;
        end
      end
      S_RUN: begin
        if (last) begin
          done_d  = (frames_inc == num_q) || cfg_abort;
          hold_d  = '0;
          gcnt_d  = gap_q - 16'd1;
          state_d = done_d ? S_IDLE : (gap_q == '0 ? S_ARM : S_GAP);
        end else if (cfg_abort) begin
          stop_d  = 1'b1;
          state_d = S_STOP;
        end else if (wd_exp) begin
          stop_d  = 1'b1;
          etmo_d  = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_STOP: begin
        if (last) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (wd_exp) begin
          stop_d  = 1'b1;
          etmo_d  = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        gcnt_d  = gcnt_q - 16'd1;
        hold_d  = '0;
        done_d  = cfg_abort;
        state_d = cfg_abort ? S_IDLE : (gcnt_q == '0 ? S_ARM : S_GAP);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      num_q    <= '0;
      len_q    <= '0;
      gap_q    <= '0;
      tmo_q    <= '0;
      gcnt_q   <= '0;
      hold_q   <= '0;
      wd_q     <= '0;
      abort_q  <= 1'b0;
      stop_q   <= 1'b0;
      done_q   <= 1'b0;
      ecfg_q   <= 1'b0;
      etmo_q   <= 1'b0;
      frames_q <= '0;
      trunc_q  <= '0;
      bytes_q  <= '0;
    end else begin
      state_q  <= state_d;
      num_q    <= num_d;
      len_q    <= len_d;
      gap_q    <= gap_d;
      tmo_q    <= tmo_d;
      gcnt_q   <= gcnt_d;
      hold_q   <= hold_d;
      wd_q     <= wd_d;
      abort_q  <= abort_d;
      stop_q   <= stop_d;
      done_q   <= done_d;
      ecfg_q   <= ecfg_d;
      etmo_q   <= etmo_d;
      frames_q <= frames_d;
      trunc_q  <= trunc_d;
      bytes_q  <= bytes_d;
    end
  end

  assign gen_start    = state_q == S_ARM;
  assign gen_stop     = stop_q;
  assign gen_length   = len_q;
  assign busy         = state_q != S_IDLE;
  assign done         = done_q;
  assign frames_sent  = frames_q;
  assign frames_trunc = trunc_q;
  assign bytes_sent   = bytes_q;
  assign err_cfg      = ecfg_q;
  assign err_timeout  = etmo_q;
endmodule
